// File: rtl/pico_ctrl_sequencer.sv
// PicoCtrl execution core: one instruction per cycle from a combinational ROM, registered PC/outputs.
// Optional macro PICO_CALL_STACK_EN adds a one-deep call/return register.
module pico_ctrl_sequencer #(
    parameter int ADDR_W      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              restart,
    input  logic [2:0]        cond_in,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic [31:0]       out_regs,
    output logic [3:0]        out_wr,
    output logic              halted,
    output logic              busy_wait
);

    typedef enum logic [1:0] {
        ST_RUN  = 2'd0,
        ST_WAIT = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    localparam logic [2:0] ACT_WRITE = 3'b001;
    localparam logic [2:0] ACT_JUMP  = 3'b010;
    localparam logic [2:0] ACT_WAIT  = 3'b011;
    localparam logic [2:0] ACT_HALT  = 3'b100;
`ifdef PICO_CALL_STACK_EN
    localparam logic [2:0] ACT_CALL  = 3'b101;
    localparam logic [2:0] ACT_RET   = 3'b110;
`endif

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic [7:0]        wait_cnt;
    logic [2:0]        sync_q [SYNC_STAGES];
`ifdef PICO_CALL_STACK_EN
    logic [ADDR_W-1:0] ret_addr;
`endif

    logic [2:0]        cond_s;
    logic [2:0]        cond_code;
    logic [2:0]        act;
    logic [1:0]        ridx;
    logic [7:0]        imm;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] target;
    logic              cond_true;

    assign rom_addr  = pc;
    assign cond_s    = sync_q[SYNC_STAGES-1];
    assign cond_code = rom_data[15:13];
    assign act       = rom_data[12:10];
    assign ridx      = rom_data[9:8];
    assign imm       = rom_data[7:0];
    assign target    = rom_data[ADDR_W-1:0];
    assign pc_inc    = pc + ADDR_W'(1);

    // Codes 01x..11x: bit 0 selects the polarity, bits 2:1 select which input (1..3 -> c0..c2).
    always_comb begin
        cond_true = 1'b0;
        case (cond_code)
            3'b000:  cond_true = 1'b1;
            3'b001:  cond_true = 1'b0;
            3'b010:  cond_true = ~cond_s[0];
            3'b011:  cond_true =  cond_s[0];
            3'b100:  cond_true = ~cond_s[1];
            3'b101:  cond_true =  cond_s[1];
            3'b110:  cond_true = ~cond_s[2];
            default: cond_true =  cond_s[2];
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            sync_q[0] <= cond_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_RUN;
            pc        <= '0;
            wait_cnt  <= '0;
            out_regs  <= '0;
            out_wr    <= '0;
            halted    <= 1'b0;
            busy_wait <= 1'b0;
`ifdef PICO_CALL_STACK_EN
            ret_addr  <= '0;
`endif
        end else begin
            out_wr <= '0;
            if (restart) begin
                state     <= ST_RUN;
                pc        <= '0;
                wait_cnt  <= '0;
                halted    <= 1'b0;
                busy_wait <= 1'b0;
            end else if (en) begin
                case (state)
                    ST_RUN: begin
                        pc <= pc_inc;
                        if (cond_true) begin
                            case (act)
                                ACT_WRITE: begin
                                    out_regs[{ridx, 3'b000} +: 8] <= imm;
                                    out_wr[ridx]                  <= 1'b1;
                                end
                                ACT_JUMP: pc <= target;
                                ACT_WAIT: begin
                                    pc        <= pc;
                                    wait_cnt  <= imm;
                                    state     <= ST_WAIT;
                                    busy_wait <= 1'b1;
                                end
                                ACT_HALT: begin
                                    pc     <= pc;
                                    state  <= ST_HALT;
                                    halted <= 1'b1;
                                end
`ifdef PICO_CALL_STACK_EN
                                ACT_CALL: begin
                                    ret_addr <= pc_inc;
                                    pc       <= target;
                                end
                                ACT_RET: pc <= ret_addr;
`endif
                                default: ;
                            endcase
                        end
                    end
                    // The cycle that finds the counter at zero is the last WAIT cycle.
                    ST_WAIT: begin
                        if (wait_cnt == 8'd0) begin
                            pc        <= pc_inc;
                            state     <= ST_RUN;
                            busy_wait <= 1'b0;
                        end else begin
                            wait_cnt <= wait_cnt - 8'd1;
                        end
                    end
                    ST_HALT: ;
                    default: begin
                        state     <= ST_RUN;
                        halted    <= 1'b0;
                        busy_wait <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pico_ctrl_sequencer.sv
// Scoreboard bench for pico_ctrl_sequencer: a reference model predicts each post-edge output set.
module tb_pico_ctrl_sequencer;
    localparam int AW = 5;
    localparam int SS = 2;
    localparam int ROM_N = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          en = 1'b0;
    logic          restart = 1'b0;
    logic [2:0]    cond_in = 3'b000;
    logic [AW-1:0] rom_addr;
    logic [15:0]   rom_data;
    logic [31:0]   out_regs;
    logic [3:0]    out_wr;
    logic          halted;
    logic          busy_wait;

    logic [15:0]   rom [ROM_N];

    pico_ctrl_sequencer #(.ADDR_W(AW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .restart(restart), .cond_in(cond_in),
        .rom_addr(rom_addr), .rom_data(rom_data), .out_regs(out_regs), .out_wr(out_wr),
        .halted(halted), .busy_wait(busy_wait)
    );

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] pc;
        logic [31:0]   regs;
        logic [3:0]    wr;
        logic          hlt;
        logic          bsy;
    } exp_t;

    exp_t exp_q[$];
    int   n_vec = 0;
    int   n_err = 0;
    bit   done  = 1'b0;

    // ---------------- reference model ----------------
    // Modes: 0 running, 1 waiting (busy_left cycles of busy_wait remain), 2 halted.
    int        m_pc, m_mode, busy_left, m_ret;
    int        m_regs [4];
    bit [2:0]  cond_hist[$];

    function automatic void model_reset();
        m_pc = 0; m_mode = 0; busy_left = 0; m_ret = 0;
        for (int i = 0; i < 4; i++) m_regs[i] = 0;
        cond_hist.delete();
        for (int i = 0; i < SS; i++) cond_hist.push_back(3'b000);
    endfunction

    function automatic bit cond_ok(int code, bit [2:0] c);
        if (code == 0) return 1'b1;
        if (code == 1) return 1'b0;
        return c[code / 2 - 1] == code[0];
    endfunction

    initial begin
        model_reset();
        forever begin
            exp_t e;
            int   wr;
            @(posedge clk);
            wr = 0;
            if (!reset_n) begin
                model_reset();
            end else begin
                // The condition visible now is cond_in as sampled SS edges earlier.
                bit [2:0] c_eff;
                c_eff = cond_hist.pop_front();
                cond_hist.push_back(cond_in);
                if (restart) begin
                    m_pc = 0; m_mode = 0; busy_left = 0;
                end else if (en) begin
                    if (m_mode == 0) begin
                        int instr, code, act, ri, imm, nxt;
                        instr = int'(rom[m_pc]);
                        code  = instr / 8192;
                        act   = (instr / 1024) % 8;
                        ri    = (instr / 256) % 4;
                        imm   = instr % 256;
                        nxt   = (m_pc + 1) % ROM_N;
                        if (!cond_ok(code, c_eff)) act = 0;
                        case (act)
                            1: begin m_regs[ri] = imm; wr = 1 << ri; m_pc = nxt; end
                            2: m_pc = imm % ROM_N;
                            3: begin m_mode = 1; busy_left = imm + 1; end
                            4: m_mode = 2;
`ifdef PICO_CALL_STACK_EN
                            5: begin m_ret = nxt; m_pc = imm % ROM_N; end
                            6: m_pc = m_ret;
`endif
                            default: m_pc = nxt;
                        endcase
                    end else if (m_mode == 1) begin
                        busy_left--;
                        if (busy_left == 0) begin
                            m_mode = 0;
                            m_pc   = (m_pc + 1) % ROM_N;
                        end
                    end
                end
            end
            e.pc   = AW'(m_pc);
            e.regs = {m_regs[3][7:0], m_regs[2][7:0], m_regs[1][7:0], m_regs[0][7:0]};
            e.wr   = 4'(wr);
            e.hlt  = (m_mode == 2);
            e.bsy  = (m_mode == 1);
            exp_q.push_back(e);
        end
    end

    // ---------------- monitor ----------------
    initial begin
        forever begin
            exp_t e;
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_vec++;
                if (rom_addr !== e.pc) begin
                    n_err++;
                    $display("FAIL pc @%0t: got %0d want %0d", $time, rom_addr, e.pc);
                end
                if (out_regs !== e.regs) begin
                    n_err++;
                    $display("FAIL out_regs @%0t: got %h want %h", $time, out_regs, e.regs);
                end
                if (out_wr !== e.wr) begin
                    n_err++;
                    $display("FAIL out_wr @%0t: got %b want %b", $time, out_wr, e.wr);
                end
                if (halted !== e.hlt) begin
                    n_err++;
                    $display("FAIL halted @%0t: got %b want %b", $time, halted, e.hlt);
                end
                if (busy_wait !== e.bsy) begin
                    n_err++;
                    $display("FAIL busy_wait @%0t: got %b want %b", $time, busy_wait, e.bsy);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [15:0] ins(int c, int a, int r, int imm);
        return {3'(c), 3'(a), 2'(r), 8'(imm)};
    endfunction

    task automatic load_rom(input int prog);
        for (int i = 0; i < ROM_N; i++) rom[i] = 16'h0000;
        case (prog)
            1: begin rom[0] = ins(0, 1, 0, 8'h01); rom[1] = ins(0, 4, 0, 0); end
            2: rom[3] = ins(4, 2, 0, 3);
            3: begin rom[5] = ins(0, 3, 0, 4); rom[7] = ins(0, 3, 0, 0); end
            4: ;
            5: begin rom[0] = ins(0, 1, 0, 8'hAA); rom[1] = ins(0, 3, 0, 10); end
            6: begin
                rom[2]    = ins(0, 5, 0, 8'h10);
                rom[5]    = ins(0, 2, 0, 5);
                rom[16]   = ins(0, 1, 2, 8'h5A);
                rom[17]   = ins(0, 6, 0, 0);
            end
            default: begin
                for (int i = 0; i < ROM_N; i++) begin
                    int a;
                    a = $urandom_range(0, 7);
                    rom[i] = ins($urandom_range(0, 7), a, $urandom_range(0, 3),
                                 (a == 3) ? $urandom_range(0, 6) : $urandom_range(0, 255));
                end
            end
        endcase
    endtask

    task automatic run_phase(input int prog, input int ncyc);
        @(negedge clk);
        reset_n = 1'b0; restart = 1'b0; en = 1'b0; cond_in = 3'b000;
        load_rom(prog);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < ncyc; i++) begin
            en = 1'b1; restart = 1'b0;
            case (prog)
                2: cond_in = (i >= 10) ? 3'b010 : 3'b000;
                3: en = !(i >= 7 && i < 10);
                5: restart = (i == 6);
                6: ;
                1, 4: ;
                default: begin
                    en      = ($urandom_range(0, 9) < 8);
                    restart = ($urandom_range(0, 39) == 0);
                    if ($urandom_range(0, 4) == 0) cond_in = 3'($urandom);
                    if ($urandom_range(0, 149) == 0) reset_n = 1'b0;
                    else reset_n = 1'b1;
                end
            endcase
            @(negedge clk);
        end
        reset_n = 1'b1;
    endtask

    initial begin
        run_phase(1, 10);
        run_phase(2, 25);
        run_phase(3, 25);
        run_phase(4, 70);
        run_phase(5, 15);
        run_phase(6, 20);
        for (int p = 0; p < 12; p++) run_phase(100 + p, 300);
        repeat (3) @(negedge clk);
        done = 1'b1;
    end

    initial begin
        fork
            wait (done);
            #2000000;
        join_any
        if (!done) begin
            n_err++;
            $display("FAIL watchdog: got stimulus still running, want completion");
        end
        if (n_vec < 12) begin
            n_err++;
            $display("FAIL vector_count: got %0d want >= 12", n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pico_ctrl_sequencer.md
Name: pico_ctrl_sequencer

Overview:
- Execution core for the PicoCtrl micro-controller.
- Each cycle: fetches one 16-bit instruction from the 32-entry instruction ROM (combinational, addressed by PC), evaluates a condition against synchronized external inputs, then writes an 8-bit output register, jumps, waits or halts.
- Sits between the instruction ROM and board-level I/O (LED banks, button/switch condition inputs).

Parameters:
- ADDR_W, 5, PC/ROM address width; jump targets use imm[ADDR_W-1:0].
- SYNC_STAGES, 2, flip-flop depth of the condition-input synchronizer (≥2).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  run enable; low = stall (PC, state and counters hold)
- restart  in  1  synchronous pulse: PC←0, state←RUN, wait counter←0; out_regs keep their values
- cond_in  in  3  raw asynchronous condition inputs c0..c2
- rom_addr  out  ADDR_W  instruction address (= PC)
- rom_data  in  16  instruction word, valid in the same cycle
- out_regs  out  32  four 8-bit output registers, reg n at [8n+7:8n]
- out_wr  out  4  one-cycle write strobe per register
- halted  out  1  high in HALT state
- busy_wait  out  1  high in WAIT state

Behaviour:
- Clock and reset: one clock domain. reset_n is asynchronous, active-low.
- Reset values: PC=0, out_regs=0, out_wr=0, state=RUN, wait counter=0, synchronizer flops=0, halted=0, busy_wait=0.
- Instruction format:
  - [15:13] cond
  - [12:10] action
  - [9:8] reg index
  - [7:0] imm
- cond codes (c = synchronized cond_in):
  - 000 always, 001 never
  - 010 c0==0, 011 c0==1
  - 100 c1==0, 101 c1==1
  - 110 c2==0, 111 c2==1
- action codes:
  - 000 nop
  - 001 write: out_regs[reg]←imm, out_wr[reg] pulses in the same cycle the register updates
  - 010 jump: PC←imm[ADDR_W-1:0]
  - 011 wait: counter←imm, enter WAIT
  - 100 halt
  - 101 call / 110 ret: only with the optional feature, otherwise nop
  - 111 nop
- Condition false → instruction acts as nop; PC+1.
- States:
  - RUN (en=1): execute rom_data at PC in one cycle. PC←PC+1 unless a jump is taken. PC wraps modulo 2^ADDR_W (31→0 for ADDR_W=5).
  - WAIT: counter decrements once per en=1 cycle. When the counter reaches 0, PC←PC+1 and state←RUN. wait with imm=0 costs exactly 1 extra cycle (enter WAIT, exit next cycle).
  - HALT: PC frozen, no writes. Left only by restart or reset.
- Jump to self with a true condition loops on that address each cycle (this is how instructions poll inputs).
- Simultaneous events: restart has priority over en and over the current instruction; restart in WAIT or HALT goes to RUN at PC=0 next cycle.
- Reset asserted mid-wait: all state clears immediately.
- en=0: no state change, out_wr=0.
- Condition inputs pass through SYNC_STAGES flops, giving SYNC_STAGES cycles of latency from a cond_in edge to an effect on cond evaluation.
- Timing: rom_addr is a register output (PC); the critical path is ROM decode → next PC / out_regs.

Optional Feature:
- Macro: PICO_CALL_STACK_EN.
- Defined: adds a one-deep return register (reset 0).
  - call (101), condition true: ret_addr←PC+1 (wrapped), PC←imm[ADDR_W-1:0].
  - ret (110), condition true: PC←ret_addr.
  - A nested call overwrites ret_addr.
- Undefined: codes 101/110 decode as nop (PC+1); no return register is synthesized.

Test Plan:
- Reset, en=1, ROM[0]={always,write,reg0,0x01}, ROM[1]={always,halt} → out_regs[7:0]=0x01 with out_wr=0001 at cycle 1; halted=1 from cycle 2; PC stays 1.
- ROM[3]={c1==0,jump,3} with cond_in[1]=0 → PC holds at 3. Set cond_in[1]=1 → PC advances to 4 within SYNC_STAGES+1 cycles.
- ROM[5]={always,wait,imm=4} → busy_wait high for 5 cycles, PC=6 afterwards. Toggling en low for 3 of those cycles extends busy_wait to 8 cycles.
- Linear program filling addresses 0..31 with nops → PC sequence 30, 31, 0, 1 (wrap), no out_wr pulses.
- restart pulsed during WAIT (counter=10) with out_regs=0x0000_00AA → next cycle PC=0, state RUN, busy_wait=0, out_regs still 0xAA.
- With PICO_CALL_STACK_EN: ROM[2]={always,call,0x10}, ROM[0x10]={always,write,reg2,0x5A}, ROM[0x11]={always,ret} → out_regs[23:16]=0x5A, then PC=3. Without the macro: PC sequence 2, 3 and reg2 stays 0.
